// File: rtl/fifo_prog_sync.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// selectable FWFT read mode, synchronous flush and read-data valid strobe.
module fifo_prog_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] fifo_in,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  rd_valid,
  input  logic [CNT_WIDTH-1:0]  pf_thresh,
  input  logic [CNT_WIDTH-1:0]  pe_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  p_full,
  output logic                  p_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  f_counter
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 wr_acc, rd_acc;

  assign full    = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign p_full  = (cnt_q >= pf_thresh);
  assign p_empty = (cnt_q <= pe_thresh);

  assign wr_acc = wr_enb & ~full;
  assign rd_acc = rd_enb & ~empty;

  assign f_counter = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = wr_enb & full;
    unf_d    = rd_enb & empty;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem_q[wr_ptr_q] <= fifo_in;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (clr) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (rd_acc) begin
        dout_q <= mem_q[rd_ptr_q];
        vld_q  <= 1'b1;
      end else begin
        vld_q  <= 1'b0;
      end
    end

    assign fifo_out = dout_q;
    assign rd_valid = vld_q;
  end else begin : g_fwft
    assign fifo_out = mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_fifo_prog_sync.sv
// Bench for fifo_prog_sync: standard and FWFT instances share stimulus
// and are checked against a queue-based reference model.
module tb_fifo_prog_sync;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int CW  = $clog2(DEP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_enb;
  logic [DW-1:0] fifo_in;
  logic          rd_enb;
  logic [CW-1:0] pf_thresh;
  logic [CW-1:0] pe_thresh;

  logic [DW-1:0] s_out, f_out;
  logic          s_vld, f_vld;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_pf, f_pf, s_pe, f_pe;
  logic          s_ovf, f_ovf, s_unf, f_unf;
  logic [CW-1:0] s_cnt, f_cnt;

  fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_enb(wr_enb), .fifo_in(fifo_in), .rd_enb(rd_enb),
    .fifo_out(s_out), .rd_valid(s_vld),
    .pf_thresh(pf_thresh), .pe_thresh(pe_thresh),
    .full(s_full), .empty(s_empty), .p_full(s_pf), .p_empty(s_pe),
    .overflow(s_ovf), .underflow(s_unf), .f_counter(s_cnt)
  );

  fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_enb(wr_enb), .fifo_in(fifo_in), .rd_enb(rd_enb),
    .fifo_out(f_out), .rd_valid(f_vld),
    .pf_thresh(pf_thresh), .pe_thresh(pe_thresh),
    .full(f_full), .empty(f_empty), .p_full(f_pf), .p_empty(f_pe),
    .overflow(f_ovf), .underflow(f_unf), .f_counter(f_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int       q[$];
  bit       m_ovf, m_unf, m_vld;
  bit [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_vld = 0; m_dout = '0;
  endtask

  task automatic model_edge(input bit w, input bit [7:0] d,
                            input bit r, input bit c);
    bit is_full, is_empty;
    if (c) begin
      model_reset();
      return;
    end
    is_full  = (q.size() == DEP);
    is_empty = (q.size() == 0);
    m_ovf = w && is_full;
    m_unf = r && is_empty;
    m_vld = 0;
    if (r && !is_empty) begin
      m_dout = 8'(q.pop_front());
      m_vld  = 1;
    end
    if (w && !is_full) q.push_back(int'(d));
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_std",  32'(s_cnt), 32'(n));
    chk("count_fwft", 32'(f_cnt), 32'(n));
    chk("full",       32'(s_full), 32'(n == DEP));
    chk("full_fwft",  32'(f_full), 32'(n == DEP));
    chk("empty",      32'(s_empty), 32'(n == 0));
    chk("empty_fwft", 32'(f_empty), 32'(n == 0));
    chk("p_full",     32'(s_pf), 32'(n >= int'(pf_thresh)));
    chk("p_empty",    32'(s_pe), 32'(n <= int'(pe_thresh)));
    chk("p_full_fwft",  32'(f_pf), 32'(n >= int'(pf_thresh)));
    chk("p_empty_fwft", 32'(f_pe), 32'(n <= int'(pe_thresh)));
    chk("overflow",   32'(s_ovf), 32'(m_ovf));
    chk("underflow",  32'(s_unf), 32'(m_unf));
    chk("overflow_fwft",  32'(f_ovf), 32'(m_ovf));
    chk("underflow_fwft", 32'(f_unf), 32'(m_unf));
    chk("rd_valid_std", 32'(s_vld), 32'(m_vld));
    chk("fifo_out_std", 32'(s_out), 32'(m_dout));
    chk("rd_valid_fwft", 32'(f_vld), 32'(n != 0));
    if (n != 0) chk("fifo_out_fwft", 32'(f_out), 32'(q[0]));
  endtask

  task automatic step(input bit w, input bit [7:0] d,
                      input bit r, input bit c);
    wr_enb  = w;
    fifo_in = d;
    rd_enb  = r;
    clr     = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; clr = 0; wr_enb = 0; rd_enb = 0; fifo_in = '0;
    pf_thresh = CW'(14);
    pe_thresh = CW'(3);
    model_reset();
    #3;
    check_all();
    #4 rst = 1'b0;

    // fill to full, p_full rises at 14
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
    chk("full_after_fill", 32'(s_full), 32'd1);
    // overflow while full
    step(1, 8'hAA, 0, 0);
    chk("ovf_pulse", 32'(s_ovf), 32'd1);
    step(0, 8'h00, 0, 0);
    chk("ovf_one_cycle", 32'(s_ovf), 32'd0);
    // write while full with read: write still rejected
    step(1, 8'hAB, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    // underflow
    step(0, 8'h00, 1, 0);
    chk("unf_pulse", 32'(s_unf), 32'd1);
    // read while empty plus write: read rejected, write accepted
    step(1, 8'h33, 1, 0);
    step(0, 8'h00, 1, 0);
    // simultaneous access at count 5
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    // streaming across pointer wrap
    step(1, 8'h80, 0, 0);
    for (int i = 1; i <= 40; i++) step(1, 8'(8'h80 + i), 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    // FWFT first-word visibility
    step(1, 8'h5C, 0, 0);
    chk("fwft_first", 32'(f_out), 32'h5C);
    step(0, 8'h00, 1, 0);
    chk("fwft_drained", 32'(f_vld), 32'd0);
    // flush at count 9 with simultaneous write
    for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hEE, 0, 1);
    chk("clr_empty", 32'(s_empty), 32'd1);
    step(1, 8'h11, 0, 0);
    step(0, 8'h00, 1, 0);

    // randomized traffic with live thresholds
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        pf_thresh = CW'($urandom_range(0, 17));
        pe_thresh = CW'($urandom_range(0, 17));
      end
      step($urandom_range(0, 99) < 55, 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) == 0);
    end

    // async reset mid-stream
    for (int i = 0; i < 6; i++) step(1, 8'(8'h90 + i), i[0], 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b0;
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_prog_sync.md
Name: fifo_prog_sync

Overview:
Parametrised synchronous FIFO, the next generation of the team's single-channel FIFO, driven and monitored through the FIFO interface.
- Generalised in data width and depth.
- Adds run-time programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and a read-data valid strobe.
- Sits between a producer and a consumer in one clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; power of 2, >= 4
FWFT, 0, 0 = standard mode (registered read data, 1-cycle latency); 1 = head word always presented on fifo_out
CNT_WIDTH, $clog2(DEPTH)+1, derived (localparam); width of f_counter and the threshold ports

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush
wr_enb  input  1  write request
fifo_in  input  DATA_WIDTH  write data
rd_enb  input  1  read/pop request
fifo_out  output  DATA_WIDTH  read data
rd_valid  output  1  fifo_out holds valid read data
pf_thresh  input  CNT_WIDTH  almost-full threshold
pe_thresh  input  CNT_WIDTH  almost-empty threshold
full  output  1  count == DEPTH
empty  output  1  count == 0
p_full  output  1  count >= pf_thresh
p_empty  output  1  count <= pe_thresh
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected
f_counter  output  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, release on clk edge):
  - Pointers = 0, f_counter = 0.
  - fifo_out = 0, rd_valid = 0 (standard mode).
  - overflow = underflow = 0.
  - empty = 1, full = 0.
  - p_empty = 1; p_full = (pf_thresh == 0).
  - Memory contents are not reset.
- Acceptance:
  - wr_acc = wr_enb & ~full.
  - rd_acc = rd_enb & ~empty.
  - Both evaluated on pre-edge state.
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Occupancy: f_counter +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Pointers: ADDR_W = $clog2(DEPTH) bits each; wrap DEPTH-1 -> 0 naturally; no special case at wrap.
- Flags:
  - full, empty, p_full, p_empty are combinational decodes of the registered count, valid in the same cycle as f_counter.
  - Thresholds are live inputs; a threshold change is reflected immediately, with no resync.
- Errors:
  - overflow is registered; high for exactly the cycle after an edge where wr_enb & full.
  - underflow likewise for rd_enb & empty.
  - Rejected requests leave memory, pointers and count untouched.
- Standard mode (FWFT = 0):
  - On rd_acc, mem[rd_ptr] is registered into fifo_out; rd_valid = 1 in the following cycle.
  - Otherwise rd_valid = 0 and fifo_out holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT = 1):
  - fifo_out = mem[rd_ptr], combinational from memory; rd_valid = ~empty.
  - The first write into an empty FIFO is visible on fifo_out in the cycle after the write edge.
  - rd_acc advances to the next word.
- clr (synchronous):
  - Pointers and count go to 0.
  - In standard mode, fifo_out goes to 0 and rd_valid to 0.
  - overflow and underflow go to 0.
  - clr overrides wr_enb and rd_enb in the same cycle; no error pulses are raised.
- Reset mid-operation: all state is dropped immediately on assertion; the first accepted write after release lands at address 0.

Test Plan:
- Reset, then fill: DEPTH=16. Write 0x01..0x10 on consecutive cycles -> f_counter steps 1..16; full=1 after the 16th write; empty=0 after the 1st. With pf_thresh=14: p_full rises at count 14.
- Overflow: while full, write 0xAA -> overflow=1 for one cycle; f_counter stays 16; a later drain returns 0x01..0x10 with no 0xAA.
- Underflow and simultaneous access:
  - rd_enb while empty -> underflow pulse; f_counter stays 0.
  - At count 5, wr_enb+rd_enb together -> count stays 5; data order is preserved.
- Standard latency and wrap: 40 write/read pairs in a streaming pattern -> each word appears on fifo_out with rd_valid one cycle after its rd_acc, in order, across pointer wrap.
- FWFT=1: write 0x5C into an empty FIFO -> next cycle fifo_out=0x5C, rd_valid=1. Read -> empty=1, rd_valid=0.
- Flush and threshold:
  - At count 9 with pe_thresh=3, assert clr together with wr_enb -> f_counter=0, empty=1, p_empty=1, no write stored.
  - Async rst mid-stream -> all outputs take their reset values immediately.
